// File: rtl/tsetlin_bank.sv
// ---------------------------------------------------------------------------
// tsetlin_bank
//
// Bank of NUM_TA independent two-action Tsetlin automata. Each automaton holds
// an unsigned state 0..2^STATE_BITS-1; the lower half selects action 0 and the
// upper half action 1, so the action is simply the state MSB. Every automaton
// accepts one reward/penalty update per cycle, all in parallel. A single
// preload port can overwrite one automaton's state, and a registered readback
// port returns the state of a selected automaton.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous, active-low reset
//   upd_en     per-automaton update strobe
//   upd_reward per-automaton feedback type (1 = reward, 0 = penalty)
//   ld_en      preload strobe
//   ld_idx     automaton to preload (out-of-range indices are ignored)
//   ld_state   preload value
//   rd_idx     automaton to read back (out-of-range indices read 0)
//   rd_state   registered state of automaton rd_idx, pre-edge value
//   alpha      current action per automaton (state MSB, no extra latency)
//   alpha_chg  one-cycle flag: action of automaton i changed at the last edge
// ---------------------------------------------------------------------------
module tsetlin_bank #(
    parameter int NUM_TA      = 8,
    parameter int STATE_BITS  = 3,
    parameter int INIT_ACTION = 0,
    parameter int IDX_W       = $clog2(NUM_TA)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_TA-1:0]     upd_en,
    input  logic [NUM_TA-1:0]     upd_reward,
    input  logic                  ld_en,
    input  logic [IDX_W-1:0]      ld_idx,
    input  logic [STATE_BITS-1:0] ld_state,
    input  logic [IDX_W-1:0]      rd_idx,
    output logic [STATE_BITS-1:0] rd_state,
    output logic [NUM_TA-1:0]     alpha,
    output logic [NUM_TA-1:0]     alpha_chg
);

    localparam int SB = STATE_BITS;

    // Last state of action 0 and first state of action 1.
    localparam logic [SB-1:0] C0        = {1'b0, {(SB-1){1'b1}}};
    localparam logic [SB-1:0] C1        = {1'b1, {(SB-1){1'b0}}};
    localparam logic [SB-1:0] S_MAX     = {SB{1'b1}};
    localparam logic [SB-1:0] S_MIN     = {SB{1'b0}};
    localparam logic [SB-1:0] RST_STATE = (INIT_ACTION != 0) ? C1 : C0;

    logic [NUM_TA-1:0][SB-1:0] s_reg;
    logic [NUM_TA-1:0][SB-1:0] s_next;
    logic [NUM_TA-1:0]         alpha_chg_reg;
    logic [NUM_TA-1:0]         alpha_chg_next;
    logic [SB-1:0]             rd_state_reg;
    logic [SB-1:0]             rd_state_next;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_TA; gi++) begin : g_ta
            logic          ld_hit;
            logic          step_up;
            logic [SB-1:0] nxt;

            // An out-of-range ld_idx never matches any gi, so it is dropped.
            assign ld_hit = ld_en && (ld_idx == IDX_W'(gi));

            // Reward pushes deeper into the current action's half, penalty
            // pushes toward the other half. For action 1 "deeper" is up, for
            // action 0 it is down, hence the XNOR.
            assign step_up = upd_reward[gi] ~^ s_reg[gi][SB-1];

            always_comb begin
                nxt = s_reg[gi];
                if (ld_hit) begin
                    nxt = ld_state;
                end else if (upd_en[gi]) begin
                    // The saturation guards only ever bite on rewards: a
                    // penalty at an extreme always moves inward.
                    if (step_up) begin
                        if (s_reg[gi] != S_MAX) begin
                            nxt = s_reg[gi] + 1'b1;
                        end
                    end else begin
                        if (s_reg[gi] != S_MIN) begin
                            nxt = s_reg[gi] - 1'b1;
                        end
                    end
                end
            end

            assign s_next[gi]         = nxt;
            assign alpha_chg_next[gi] = nxt[SB-1] ^ s_reg[gi][SB-1];
            assign alpha[gi]          = s_reg[gi][SB-1];
        end
    endgenerate

    // Readback mux; indices with no matching automaton fall through to zero.
    always_comb begin
        rd_state_next = '0;
        for (int i = 0; i < NUM_TA; i++) begin
            if (rd_idx == IDX_W'(i)) begin
                rd_state_next = s_reg[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            s_reg         <= {NUM_TA{RST_STATE}};
            alpha_chg_reg <= '0;
            rd_state_reg  <= '0;
        end else begin
            s_reg         <= s_next;
            alpha_chg_reg <= alpha_chg_next;
            rd_state_reg  <= rd_state_next;
        end
    end

    assign alpha_chg = alpha_chg_reg;
    assign rd_state  = rd_state_reg;

endmodule

// File: tb/tb_tsetlin_bank.sv
// ---------------------------------------------------------------------------
// tb_tsetlin_bank
//
// Directed test of tsetlin_bank. Main instance uses NUM_TA=8, STATE_BITS=3,
// INIT_ACTION=0 and is checked every cycle against an arithmetic model of the
// automata plus hand-computed literal expectations. A second instance with
// INIT_ACTION=1 checks the alternate reset state, and a NUM_TA=6 instance
// checks that an out-of-range preload/readback index has no effect.
// ---------------------------------------------------------------------------
module tb_tsetlin_bank;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] upd_en = '0;
    logic [7:0] upd_reward = '0;
    logic       ld_en = 1'b0;
    logic [2:0] ld_idx = '0;
    logic [2:0] ld_state = '0;
    logic [2:0] rd_idx = '0;
    logic [2:0] rd_state;
    logic [7:0] alpha;
    logic [7:0] alpha_chg;

    logic [2:0] rd_state1;
    logic [7:0] alpha1;
    logic [7:0] alpha_chg1;

    logic       ld_en6 = 1'b0;
    logic [2:0] ld_idx6 = '0;
    logic [2:0] ld_state6 = '0;
    logic [2:0] rd_idx6 = '0;
    logic [2:0] rd_state6;
    logic [5:0] alpha6;
    logic [5:0] alpha_chg6;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    bit chk_en   = 1'b0;

    always #5 clk = ~clk;

    tsetlin_bank #(.NUM_TA(8), .STATE_BITS(3), .INIT_ACTION(0)) dut (
        .clk(clk), .rst(rst), .upd_en(upd_en), .upd_reward(upd_reward),
        .ld_en(ld_en), .ld_idx(ld_idx), .ld_state(ld_state),
        .rd_idx(rd_idx), .rd_state(rd_state), .alpha(alpha), .alpha_chg(alpha_chg)
    );

    tsetlin_bank #(.NUM_TA(8), .STATE_BITS(3), .INIT_ACTION(1)) dut1 (
        .clk(clk), .rst(rst), .upd_en(8'h00), .upd_reward(8'h00),
        .ld_en(1'b0), .ld_idx(3'd0), .ld_state(3'd0),
        .rd_idx(rd_idx), .rd_state(rd_state1), .alpha(alpha1), .alpha_chg(alpha_chg1)
    );

    tsetlin_bank #(.NUM_TA(6), .STATE_BITS(3), .INIT_ACTION(0)) dut6 (
        .clk(clk), .rst(rst), .upd_en(6'h00), .upd_reward(6'h00),
        .ld_en(ld_en6), .ld_idx(ld_idx6), .ld_state(ld_state6),
        .rd_idx(rd_idx6), .rd_state(rd_state6), .alpha(alpha6), .alpha_chg(alpha_chg6)
    );

    // ---------------- behavioural model (C0=3, C1=4, M=7) ----------------
    int         ms [8];
    logic [7:0] m_chg = '0;
    int         m_rd  = 0;

    function automatic int model_next(int s, bit en, bit rew, bit ld, int ldv);
        if (ld)  return ldv;
        if (!en) return s;
        if (s >= 4) return rew ? ((s == 7) ? 7 : s + 1) : s - 1;
        else        return rew ? ((s == 0) ? 0 : s - 1) : s + 1;
    endfunction

    function automatic logic [7:0] model_alpha();
        logic [7:0] a;
        for (int i = 0; i < 8; i++) a[i] = (ms[i] >= 4);
        return a;
    endfunction

    always @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 8; i++) ms[i] <= 3;
            m_chg <= '0;
            m_rd  <= 0;
        end else begin
            m_rd <= ms[rd_idx];
            for (int i = 0; i < 8; i++) begin
                ms[i]    <= model_next(ms[i], upd_en[i], upd_reward[i],
                                       ld_en && (ld_idx == 3'(i)), int'(ld_state));
                m_chg[i] <= (model_next(ms[i], upd_en[i], upd_reward[i],
                                        ld_en && (ld_idx == 3'(i)), int'(ld_state)) >= 4)
                            != (ms[i] >= 4);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Per-cycle compare against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_alpha", 32'(alpha), 32'(model_alpha()));
            chk("model_alpha_chg", 32'(alpha_chg), 32'(m_chg));
            chk("model_rd_state", 32'(rd_state), 32'(m_rd));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        $display("cyc %0d rst=%b upd_en=%h rew=%h ld=%b/%0d/%0d rd_idx=%0d -> alpha=%h chg=%h rd=%0d",
                 cyc, rst, upd_en, upd_reward, ld_en, ld_idx, ld_state, rd_idx,
                 alpha, alpha_chg, rd_state);
    endtask

    int exp_rd2 [5] = '{3, 2, 1, 0, 0};

    initial begin
        // 1. reset
        tick();
        tick();
        rst = 1'b1;
        chk("rst_alpha", 32'(alpha), 32'h00);
        chk("rst_alpha_chg", 32'(alpha_chg), 32'h00);
        chk("rst_rd_state", 32'(rd_state), 32'd0);
        chk("rst1_alpha", 32'(alpha1), 32'hFF);
        chk("rst1_alpha_chg", 32'(alpha_chg1), 32'h00);
        chk("rst1_rd_state", 32'(rd_state1), 32'd0);
        chk_en = 1'b1;
        tick();
        chk("rst_s0", 32'(rd_state), 32'd3);
        chk("rst1_s0", 32'(rd_state1), 32'd4);
        chk("rst6_s0", 32'(rd_state6), 32'd3);

        // 2. reward saturation at the bottom
        upd_en = 8'h01; upd_reward = 8'h01; rd_idx = 3'd0;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("sat_rd", 32'(rd_state), 32'(exp_rd2[k]));
            chk("sat_alpha0", 32'(alpha[0]), 32'd0);
            chk("sat_chg", 32'(alpha_chg), 32'h00);
        end
        upd_en = 8'h00;
        tick();
        chk("sat_rd_final", 32'(rd_state), 32'd0);

        // 3. penalty crossing both ways
        upd_en = 8'h02; upd_reward = 8'h00; rd_idx = 3'd1;
        tick();
        chk("cross_up_alpha", 32'(alpha), 32'h02);
        chk("cross_up_chg", 32'(alpha_chg), 32'h02);
        upd_en = 8'h00;
        tick();
        chk("cross_hold_chg", 32'(alpha_chg), 32'h00);
        chk("cross_rd4", 32'(rd_state), 32'd4);
        upd_en = 8'h02;
        tick();
        chk("cross_dn_alpha", 32'(alpha), 32'h00);
        chk("cross_dn_chg", 32'(alpha_chg), 32'h02);
        upd_en = 8'h00;
        tick();
        chk("cross_rd3", 32'(rd_state), 32'd3);

        // 4. preload, upper saturation, parallel updates
        ld_en = 1'b1; ld_idx = 3'd5; ld_state = 3'd6;
        tick();
        chk("ld5_alpha", 32'(alpha), 32'h20);
        chk("ld5_chg", 32'(alpha_chg), 32'h20);
        ld_en = 1'b0; upd_en = 8'hFF; upd_reward = 8'hAA;
        tick();
        chk("par_alpha", 32'(alpha), 32'h74);
        chk("par_chg", 32'(alpha_chg), 32'h54);
        upd_en = 8'h20; upd_reward = 8'h20; rd_idx = 3'd5;
        tick();
        chk("top_alpha", 32'(alpha), 32'h74);
        chk("top_chg", 32'(alpha_chg), 32'h00);
        chk("top_rd_pre", 32'(rd_state), 32'd7);
        upd_en = 8'h00;
        tick();
        chk("top_rd_hold", 32'(rd_state), 32'd7);

        // 5. preload/update collision (bring S2 back to 3 first)
        ld_en = 1'b1; ld_idx = 3'd2; ld_state = 3'd3;
        tick();
        chk("ld2_alpha", 32'(alpha), 32'h70);
        ld_state = 3'd6; upd_en = 8'h04; upd_reward = 8'h00; rd_idx = 3'd2;
        tick();
        chk("coll_alpha", 32'(alpha), 32'h74);
        chk("coll_chg", 32'(alpha_chg), 32'h04);
        ld_en = 1'b0; upd_en = 8'h00;
        tick();
        chk("coll_rd", 32'(rd_state), 32'd6);

        // out-of-range preload/readback on the 6-wide bank
        ld_en6 = 1'b1; ld_idx6 = 3'd7; ld_state6 = 3'd7;
        tick();
        ld_idx6 = 3'd6;
        tick();
        ld_en6 = 1'b0;
        chk("oor_alpha6", 32'(alpha6), 32'h00);
        chk("oor_chg6", 32'(alpha_chg6), 32'h00);
        for (int k = 0; k < 8; k++) begin
            rd_idx6 = 3'(k);
            tick();
            chk("oor_rd6", 32'(rd_state6), (k < 6) ? 32'd3 : 32'd0);
        end

        // 6. random traffic, then reset with a penalty pending
        for (int k = 0; k < 40; k++) begin
            upd_en     = 8'($urandom);
            upd_reward = 8'($urandom);
            ld_en      = ($urandom_range(0, 3) == 0);
            ld_idx     = 3'($urandom_range(0, 7));
            ld_state   = 3'($urandom_range(0, 7));
            rd_idx     = 3'($urandom_range(0, 7));
            tick();
        end
        ld_en = 1'b0; upd_en = 8'hFF; upd_reward = 8'h00; rst = 1'b0;
        tick();
        rst = 1'b1; upd_en = 8'h00; rd_idx = 3'd4;
        chk("mid_rst_alpha", 32'(alpha), 32'h00);
        chk("mid_rst_chg", 32'(alpha_chg), 32'h00);
        chk("mid_rst_rd", 32'(rd_state), 32'd0);
        tick();
        chk("mid_rst_s4", 32'(rd_state), 32'd3);
        tick();

        @(negedge clk);
        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tsetlin_bank.md
Name: tsetlin_bank

Overview:
- Parametrised bank of NUM_TA independent two-action Tsetlin automata, each with 2^STATE_BITS states.
- Every automaton can take one reward or penalty update per cycle, all in parallel.
- Adds what the fixed 3-bit single automaton lacked: per-automaton state preload, registered state readback, and action-change flags.
- Sits between the clause feedback logic and the clause include/exclude inputs. alpha[i] drives literal include for automaton i.

Parameters:
- NUM_TA, 8, number of automata in the bank (>=2).
- STATE_BITS, 3, state register width per automaton; 2^STATE_BITS states, half per action (>=2).
- INIT_ACTION, 0, action every automaton sits at after reset (0 or 1).
- IDX_W, $clog2(NUM_TA), derived index width; not overridden.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-low; sampled on the rising edge of clk.
- upd_en  in  NUM_TA  per-automaton update strobe.
- upd_reward  in  NUM_TA  per-automaton feedback type when upd_en[i]=1: 1=reward, 0=penalty.
- ld_en  in  1  preload strobe.
- ld_idx  in  IDX_W  automaton to preload.
- ld_state  in  STATE_BITS  preload value.
- rd_idx  in  IDX_W  automaton to read back.
- rd_state  out  STATE_BITS  registered state of automaton rd_idx.
- alpha  out  NUM_TA  current action per automaton: the MSB of its state.
- alpha_chg  out  NUM_TA  one-cycle flag: the action of automaton i changed at the last edge.

Behaviour:
- State encoding:
  - S[i] is unsigned, range 0..M where M = 2^STATE_BITS-1. C0 = 2^(STATE_BITS-1)-1 and C1 = C0+1.
  - States 0..C0 give action 0; states C1..M give action 1.
  - alpha[i] = S[i][MSB]. It is taken directly from the state register with no added latency.
- Reset (rst=0 at an edge):
  - All S[i] load C0 if INIT_ACTION=0, otherwise C1. alpha = all INIT_ACTION.
  - alpha_chg=0 and rd_state=0.
  - Reset overrides every other input, including in the middle of an update sequence.
- Update, per automaton, on an edge with rst=1, upd_en[i]=1 and no preload hit:
  - Reward, action 0: S-1, saturating at 0.
  - Reward, action 1: S+1, saturating at M.
  - Penalty, action 0: S+1. A penalty at C0 goes to C1, so the action flips.
  - Penalty, action 1: S-1. A penalty at C1 goes to C0, so the action flips.
  - A penalty can never wrap. A reward at a saturated extreme holds the state.
  - upd_en[i]=0 holds S[i]; upd_reward[i] is then don't-care.
- Preload:
  - ld_en=1 with ld_idx<NUM_TA writes ld_state into S[ld_idx] on the edge.
  - Preload wins over a same-cycle update to the same index. Updates to the other indices proceed normally.
  - ld_idx>=NUM_TA: the preload is ignored with no side effects.
- Latency: an update or preload takes effect at the next edge; the new alpha is visible immediately after that edge.
- alpha_chg:
  - Registered. alpha_chg[i]=1 for exactly the cycle after an edge at which S[i][MSB] changed, whether the cause was an update or a preload. Otherwise 0.
  - Not set by reset.
- Readback:
  - rd_state is registered with 1-cycle latency and samples S[rd_idx] as it was before the edge, i.e. the pre-update value.
  - rd_idx>=NUM_TA returns 0.
- No combinational path from any input to any output.

Test Plan (NUM_TA=8, STATE_BITS=3, INIT_ACTION=0; C0=3, C1=4, M=7):
1. Reset: hold rst=0 for 2 edges, then release -> all S=3, alpha=0x00, alpha_chg=0x00, rd_state=0. Repeat with INIT_ACTION=1 -> all S=4, alpha=0xFF.
2. Reward saturation: upd_en=0x01 with reward for 5 edges -> S0 goes 2,1,0,0,0. alpha[0] stays 0 and alpha_chg stays 0x00 throughout. rd_idx=0 shows each value one cycle later.
3. Penalty crossing: upd_en=0x02 with penalty -> S1 goes 3->4, alpha=0x02, alpha_chg=0x02 for one cycle. A second penalty -> S1=3, alpha=0x00, alpha_chg=0x02 pulses again.
4. Upper saturation and parallel updates: preload S5=6, then upd_en=0xFF with upd_reward=0xAA:
   - S5 -> 7; another reward -> stays at 7.
   - Penalised automata with S=3 -> 4, and their alpha bits set.
   - Rewarded automata with S=3 -> 2.
5. Collision: ld_en=1, ld_idx=2, ld_state=6, and upd_en=0x04 penalty on the same edge -> S2=6 (the preload wins), alpha[2]=1, alpha_chg=0x04. ld_idx=9 is not a legal value at IDX_W=3; use NUM_TA=6 with ld_idx=7 -> no state changes.
6. Reset mid-operation: run random updates, then assert rst=0 for one edge -> the next cycle shows all S=3, alpha=0x00, alpha_chg=0x00, even though a penalty was pending on that edge.
